// File: rtl/pwm_led.sv
// Breathing-LED generator: three cascaded counters (micro tick, PWM period,
// ramp step) and a ramp direction bit produce a PWM LED drive whose duty
// ramps linearly up to ~100% and back down to ~0%, repeating forever.
module pwm_led #(
  parameter int unsigned CNT_2US = 100,   // sys_clk cycles per micro tick
  parameter int unsigned CNT_2MS = 1000,  // micro ticks per PWM period
  parameter int unsigned CNT_2S  = 1000   // PWM periods per ramp half
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic led
);

  localparam int unsigned US_W  = (CNT_2US > 1) ? $clog2(CNT_2US) : 1;
  localparam int unsigned MS_W  = (CNT_2MS > 1) ? $clog2(CNT_2MS) : 1;
  localparam int unsigned S_W   = (CNT_2S  > 1) ? $clog2(CNT_2S)  : 1;
  localparam int unsigned CMP_W = (MS_W > S_W) ? MS_W : S_W;

  localparam logic [US_W-1:0] US_MAX = US_W'(CNT_2US - 1);
  localparam logic [MS_W-1:0] MS_MAX = MS_W'(CNT_2MS - 1);
  localparam logic [S_W-1:0]  S_MAX  = S_W'(CNT_2S - 1);

  typedef enum logic {
    DIR_UP   = 1'b0,  // brightening
    DIR_DOWN = 1'b1   // dimming
  } dir_t;

  logic [US_W-1:0]  cnt_us;
  logic [MS_W-1:0]  cnt_ms;
  logic [S_W-1:0]   cnt_s;
  dir_t             dir;
  dir_t             dir_next;
  logic             tick_us;
  logic             tick_ms;
  logic             tick_s;
  logic [CMP_W-1:0] ms_cmp;
  logic [CMP_W-1:0] s_cmp;
  logic             led_next;

  // Cascaded terminal-count strobes
  always_comb begin
    tick_us = (cnt_us == US_MAX);
    tick_ms = tick_us && (cnt_ms == MS_MAX);
    tick_s  = tick_ms && (cnt_s == S_MAX);
  end

  // Micro-tick counter: free-running, wraps at CNT_2US-1
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_us <= '0;
    end else if (tick_us) begin
      cnt_us <= '0;
    end else begin
      cnt_us <= cnt_us + 1'b1;
    end
  end

  // PWM-period counter: advances on each micro tick
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_ms <= '0;
    end else if (tick_ms) begin
      cnt_ms <= '0;
    end else if (tick_us) begin
      cnt_ms <= cnt_ms + 1'b1;
    end
  end

  // Ramp-step counter: advances once per PWM period
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_s <= '0;
    end else if (tick_s) begin
      cnt_s <= '0;
    end else if (tick_ms) begin
      cnt_s <= cnt_s + 1'b1;
    end
  end

  // Direction state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dir <= DIR_UP;
    end else begin
      dir <= dir_next;
    end
  end

  // Direction next-state: flip at the end of each ramp half
  always_comb begin
    dir_next = dir;
    if (tick_s) begin
      dir_next = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
    end
  end

  // PWM compare: lit while position is below the step (up) or at/above it (down)
  always_comb begin
    ms_cmp   = CMP_W'(cnt_ms);
    s_cmp    = CMP_W'(cnt_s);
    led_next = 1'b0;
    case (dir)
      DIR_UP:   led_next = (ms_cmp <  s_cmp);
      DIR_DOWN: led_next = (ms_cmp >= s_cmp);
      default:  led_next = 1'b0;
    endcase
  end

  // Registered LED output, one clock behind the counter compare
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led <= 1'b0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_pwm_led.sv
// Self-checking bench for pwm_led: an arithmetic model of the breathing
// waveform (derived from elapsed cycles since reset release) is compared with
// the DUT every cycle, alongside literal per-period duty counts, a periodicity
// check, internal counter probes and randomized asynchronous resets.
module tb_pwm_led;

  localparam int US = 2;
  localparam int MS = 10;
  localparam int S  = 10;
  localparam int PERIOD = US * MS;      // 20 clk
  localparam int HALF   = PERIOD * S;   // 200 clk
  localparam int CYCLE  = 2 * HALF;     // 400 clk

  logic sys_clk;
  logic sys_rst_n;
  logic led;

  int errors = 0;
  int checks = 0;

  int n;                 // rising edges since reset release
  bit phase1 = 1'b1;     // first uninterrupted run, used for periodicity
  bit hist [0:1200];
  int hi_cnt = 0;
  bit prev_cmp = 1'b0;

  // Literal high-cycle counts for PWM periods 0..19 of one breathing cycle
  int hi_tab [0:19] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18,
                        20, 18, 16, 14, 12, 10, 8, 6, 4, 2};

  pwm_led #(.CNT_2US(US), .CNT_2MS(MS), .CNT_2S(S)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .led      (led)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) n <= 0;
    else            n <= n + 1;
  end

  // Expected led after `cnt` edges: driven by the position one edge earlier
  function automatic bit model_led(input int cnt);
    int t, k, d, m;
    if (cnt == 0) return 1'b0;
    t = cnt - 1;
    k = (t / PERIOD) % S;
    d = (t / HALF) % 2;
    m = (t / US) % MS;
    return (d == 1) ? (m >= k) : (m < k);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t n=%0d: got %0d expected %0d", name, $time, n, act, exp);
    end
  endtask

  // Per-cycle compare process
  always @(negedge sys_clk) begin
    bit cmp_now;
    cmp_now = (int'(dut.dir) == 1) ? (int'(dut.cnt_ms) >= int'(dut.cnt_s))
                                   : (int'(dut.cnt_ms) <  int'(dut.cnt_s));
    if (!sys_rst_n) begin
      check("led_in_reset", int'(led), 0);
      check("cnt_us_in_reset", int'(dut.cnt_us), 0);
      check("cnt_ms_in_reset", int'(dut.cnt_ms), 0);
      check("cnt_s_in_reset", int'(dut.cnt_s), 0);
      hi_cnt = 0;
    end else begin
      check("led_model", int'(led), int'(model_led(n)));
      check("cnt_ms_probe", int'(dut.cnt_ms), (n / US) % MS);
      check("cnt_s_probe", int'(dut.cnt_s), (n / PERIOD) % S);
      check("dir_probe", int'(dut.dir), (n / HALF) % 2);
      if (n >= 1) begin
        check("led_latency", int'(led), int'(prev_cmp));
        if (led) hi_cnt++;
        if (n % PERIOD == 0) begin
          check("period_high_count", hi_cnt, hi_tab[((n / PERIOD) - 1) % 20]);
          hi_cnt = 0;
        end
      end
      if (phase1 && n <= 1200) begin
        hist[n] = led;
        if (n > CYCLE) check("periodicity", int'(led), int'(hist[n - CYCLE]));
      end
    end
    prev_cmp = cmp_now;
  end

  task automatic run_cycles(input int c);
    repeat (c) @(posedge sys_clk);
  endtask

  // Assert reset asynchronously a few ns after a rising edge and confirm
  // led drops without waiting for a clock edge.
  task automatic async_reset(input int hold_cycles);
    @(posedge sys_clk);
    #(3 + $urandom_range(0, 4));
    sys_rst_n = 1'b0;
    #1;
    check("led_async_clear", int'(led), 0);
    repeat (hold_cycles) @(negedge sys_clk);
    #5;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    #1;
    check("led_reset_start", int'(led), 0);
    #99;
    sys_rst_n = 1'b1;

    // Three full breathing cycles uninterrupted
    run_cycles(1200);
    #1;
    phase1 = 1'b0;

    // Run into a dimming period where led is lit, then reset mid-period
    run_cycles(249);
    #1;
    check("dimming_lit_before_reset", int'(led), 1);
    check("dimming_dir_before_reset", int'(dut.dir), 1);
    async_reset(3);

    // Dark first period after release
    run_cycles(PERIOD + 1);

    // Randomized reset points and run lengths
    for (int i = 0; i < 5; i++) begin
      run_cycles($urandom_range(30, 450));
      async_reset($urandom_range(1, 4));
    end
    run_cycles(CYCLE + 10);

    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
